// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int WORD_WIDTH         = 32;
  localparam int DMEM_DEFAULT_DEPTH = 1024;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_sram_array.sv
// Byte-enabled word array, single synchronous read/write port, write-first.
module dmem_sram_array
  import dmem_responder_pkg::*;
#(
  parameter int DW    = WORD_WIDTH,
  parameter int DEPTH = DMEM_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [AW-1:0]   idx_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] merged;

  always_comb begin
    merged = mem_q[idx_i];
    for (int b = 0; b < DW/8; b++) begin
      if (be_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  // No reset: contents survive rst_n, as an SRAM macro would.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[idx_i] <= merged;
      rdata_q <= we_i ? merged : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the core req/gnt/rvalid port; optional grant wait
// states are enabled by defining DMEM_WAIT_STATES_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = DMEM_DEFAULT_DEPTH,
  parameter logic [WORD_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  input  logic [WORD_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [WORD_WIDTH/8-1:0] be_i,
  input  logic [WORD_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [WORD_WIDTH-1:0]   rdata_o,
  output logic                    oob_err_o,
  input  logic [3:0]              wait_cfg_i
);

  localparam int                    AW   = $clog2(DEPTH_WORDS);
  localparam logic [WORD_WIDTH-1:0] SPAN = WORD_WIDTH'(DEPTH_WORDS * 4);

  logic [WORD_WIDTH-1:0] offset;
  logic [WORD_WIDTH-1:0] sram_rdata;
  logic                  in_range;
  logic                  txn;
  logic                  unused_bits;
  logic                  rvalid_q, rvalid_d;
  logic                  rd_sel_q, rd_sel_d;
  logic                  oob_q, oob_d;

  assign offset   = addr_i - BASE_ADDR;
  assign in_range = (addr_i >= BASE_ADDR) && (offset < SPAN);
  assign txn      = req_i && gnt_o;

`ifdef DMEM_WAIT_STATES_EN
  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Counter loads wait_cfg_i-1 so the grant lands exactly wait_cfg_i cycles late.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (wait_cfg_i == 4'd0) begin
            gnt_o = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_cfg_i - 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!req_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          gnt_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign unused_bits = ^offset[1:0];
`else
  assign gnt_o       = req_i;
  assign unused_bits = ^{offset[1:0], wait_cfg_i};
`endif

  always_comb begin
    rvalid_d = txn;
    rd_sel_d = txn && !we_i && in_range;
    oob_d    = oob_q || (txn && !in_range);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rd_sel_q <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rd_sel_q <= rd_sel_d;
      oob_q    <= oob_d;
    end
  end

  dmem_sram_array #(
    .DW    (WORD_WIDTH),
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .en_i    (txn && in_range),
    .we_i    (we_i),
    .idx_i   (offset[AW+1:2]),
    .be_i    (be_i),
    .wdata_i (wdata_i),
    .rdata_o (sram_rdata)
  );

  // Write responses and out-of-range reads return zero.
  assign rdata_o   = rd_sel_q ? sram_rdata : '0;
  assign rvalid_o  = rvalid_q;
  assign oob_err_o = oob_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses queued at grant, checked at rvalid.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] LIMIT = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [3:0]  wait_cfg = '0;
  logic        gnt, rvalid, oob;
  logic [31:0] rdata;

  dmem_responder #(
    .WORD_WIDTH  (32),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .addr_i     (addr),
    .we_i       (we),
    .be_i       (be),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .oob_err_o  (oob),
    .wait_cfg_i (wait_cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rvalid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_rvalid: rvalid_o=1 at cycle %0d, required no response", cyc);
      end else begin
        e = sb.pop_front();
        n_vec++;
        if (rdata !== e.data) begin
          n_err++;
          $display("FAIL rdata: got %h, required %h (granted cycle %0d)", rdata, e.data, e.cyc);
        end
        n_vec++;
        if (cyc !== e.cyc + 1) begin
          n_err++;
          $display("FAIL rvalid_latency: response at cycle %0d, required %0d", cyc, e.cyc + 1);
        end
      end
    end else if (rst_n && sb.size() > 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_rvalid: rvalid_o=0 at cycle %0d, required 1 for grant at %0d", cyc, e.cyc);
    end
  end

  function automatic logic [31:0] expect_read(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    if (a >= LIMIT) return 32'h0;
    return model.exists(idx) ? model[idx] : 32'h0;
  endfunction

  // One request, held until granted; returns at negedge+1 of the grant cycle.
  task automatic access(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input int exp_wait);
    int          waited;
    int          idx;
    logic [31:0] base;
    waited = 0;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    #1;
    while (!gnt && waited < 16) begin
      @(negedge clk);
      #1;
      waited++;
    end
    n_vec++;
    if (!gnt) begin
      n_err++;
      $display("FAIL gnt_timeout addr=%h: gnt_o=0 after %0d cycles, required grant", a, waited);
      req = 1'b0;
      return;
    end
    n_vec++;
    if (waited !== exp_wait) begin
      n_err++;
      $display("FAIL gnt_latency addr=%h: granted after %0d cycles, required %0d", a, waited, exp_wait);
    end
    idx = int'(a >> 2);
    if (w) begin
      if (a < LIMIT) begin
        base = model.exists(idx) ? model[idx] : 32'h0;
        for (int k = 0; k < 4; k++) if (b[k]) base[8*k +: 8] = d[8*k +: 8];
        model[idx] = base;
      end
      sb.push_back('{32'h0, cyc});
    end else begin
      sb.push_back('{expect_read(a), cyc});
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b, required 0", rvalid); end
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
    n_vec++;
    if (oob !== 1'b0) begin n_err++; $display("FAIL reset_oob: got %b, required 0", oob); end
    n_vec++;
    if (gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b, required 0", gnt); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_write_read();
    access(32'h10, 1'b1, 4'hF, 32'hCAFEBABE, 0);
    access(32'h10, 1'b0, 4'h0, 32'h0, 0);
    idle(2);
  endtask

  task automatic test_byte_enable();
    access(32'h20, 1'b1, 4'hF, 32'hFFFFFFFF, 0);
    access(32'h20, 1'b1, 4'b0101, 32'h00000000, 0);
    access(32'h20, 1'b1, 4'b0000, 32'h12345678, 0);
    access(32'h20, 1'b0, 4'b1010, 32'h0, 0);
    access(32'h23, 1'b0, 4'h0, 32'h0, 0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) access(32'(4 * i), 1'b1, 4'hF, 32'(i), 0);
    idle(1);
    for (int i = 0; i < 8; i++) access(32'(4 * i), 1'b0, 4'h0, 32'h0, 0);
    idle(2);
  endtask

  task automatic test_wait_states();
`ifdef DMEM_WAIT_STATES_EN
    wait_cfg = 4'd3;
    access(32'h8, 1'b0, 4'h0, 32'h0, 3);
    idle(1);
    wait_cfg = 4'd1;
    access(32'h40, 1'b1, 4'hF, 32'hA5A5_0001, 1);
    idle(1);
    // wait_cfg changed mid-wait must not shorten the wait
    @(negedge clk);
    wait_cfg = 4'd2; req = 1'b1; addr = 32'h4; we = 1'b0; be = 4'h0;
    #1;
    n_vec++;
    if (gnt !== 1'b0) begin n_err++; $display("FAIL midwait_gnt1: got %b, required 0", gnt); end
    @(negedge clk);
    wait_cfg = 4'd0;
    #1;
    n_vec++;
    if (gnt !== 1'b0) begin n_err++; $display("FAIL midwait_gnt2: got %b, required 0", gnt); end
    @(negedge clk);
    #1;
    n_vec++;
    if (gnt !== 1'b1) begin
      n_err++;
      $display("FAIL midwait_gnt3: got %b, required 1", gnt);
    end else begin
      sb.push_back('{expect_read(32'h4), cyc});
    end
    idle(2);
`else
    wait_cfg = 4'd3;
    access(32'h8, 1'b0, 4'h0, 32'h0, 0);
    access(32'h40, 1'b1, 4'hF, 32'hA5A5_0001, 0);
    access(32'h40, 1'b0, 4'h0, 32'h0, 0);
    idle(2);
`endif
    wait_cfg = 4'd0;
  endtask

  task automatic test_oob();
    access(LIMIT - 32'd4, 1'b1, 4'hF, 32'h1357_9BDF, 0);
    access(LIMIT - 32'd4, 1'b0, 4'h0, 32'h0, 0);
    idle(1);
    n_vec++;
    if (oob !== 1'b0) begin n_err++; $display("FAIL oob_last_word: got %b, required 0", oob); end
    access(LIMIT, 1'b0, 4'h0, 32'h0, 0);
    idle(1);
    n_vec++;
    if (oob !== 1'b1) begin n_err++; $display("FAIL oob_set: got %b, required 1", oob); end
    access(LIMIT + 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 0);
    access(32'h10, 1'b0, 4'h0, 32'h0, 0);
    access(32'h0, 1'b0, 4'h0, 32'h0, 0);
    idle(2);
    n_vec++;
    if (oob !== 1'b1) begin n_err++; $display("FAIL oob_sticky: got %b, required 1", oob); end
  endtask

  task automatic test_reset_mid();
    access(32'h10, 1'b0, 4'h0, 32'h0, 0);
    @(posedge clk);
    #2;
    n_vec++;
    if (rvalid !== 1'b1) begin n_err++; $display("FAIL inflight_rvalid: got %b, required 1", rvalid); end
    rst_n = 1'b0;
    req = 1'b0;
    sb.delete();
    #1;
    n_vec++;
    if (rvalid !== 1'b0) begin n_err++; $display("FAIL midreset_rvalid: got %b, required 0", rvalid); end
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL midreset_rdata: got %h, required 0", rdata); end
    n_vec++;
    if (oob !== 1'b0) begin n_err++; $display("FAIL midreset_oob: got %b, required 0", oob); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    access(32'h10, 1'b0, 4'h0, 32'h0, 0);
    access(32'h4, 1'b0, 4'h0, 32'h0, 0);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_wait_states();
    test_oob();
    test_reset_mid();
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
